riscv_csr_trap_unit: RTL and testbench

- Machine-mode CSR file with in-block trap entry/exit sequencing, interrupt pending evaluation and parametrised-width performance counters.
- Successor to the plain CSR register file: adds atomic RW/RS/RC updates, trap/mret side effects, minstret with multi-retire, vectored mtvec and illegal-CSR detection.
- Sits beside the dual-issue commit stage. Commit drives trap/mret/retire events; the fetch unit consumes trap_vector and mepc_out.

---
 rtl/riscv_csr_trap_unit_if.sv | 12 +
 rtl/riscv_csr_trap_unit.sv | 184 ++++++++++++++++++
 tb/tb_riscv_csr_trap_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_csr_trap_unit_if.sv
// CSR access bus between the commit stage (master) and the machine-mode CSR/trap unit (slave).
interface riscv_csr_trap_unit_if;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_op;
  logic        illegal_csr;

  modport master (output csr_raddr, csr_waddr, csr_wdata, csr_op, input csr_rdata, illegal_csr);
  modport slave  (input csr_raddr, csr_waddr, csr_wdata, csr_op, output csr_rdata, illegal_csr);
endinterface

// File: rtl/riscv_csr_trap_unit.sv
// Machine-mode CSR file with trap entry/mret sequencing, interrupt pending and mcycle/minstret.
// Optional mcountinhibit (0x320) is built in when CSR_MCOUNTINHIBIT_EN is defined.
module riscv_csr_trap_unit #(
  parameter  int CNT_W      = 64,
  parameter  int NUM_RETIRE = 2,
  localparam int RET_W      = $clog2(NUM_RETIRE + 1)
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [31:0]              cpu_id,
  input  logic [31:0]              misa,
  riscv_csr_trap_unit_if.slave     csr,
  input  logic [RET_W-1:0]         retire_cnt,
  input  logic                     trap_valid,
  input  logic [31:0]              trap_cause,
  input  logic [31:0]              trap_pc,
  input  logic [31:0]              trap_tval,
  input  logic                     mret_valid,
  input  logic                     irq_ext,
  input  logic                     irq_timer,
  input  logic                     irq_sw,
  output logic                     irq_pending,
  output logic [31:0]              trap_vector,
  output logic [31:0]              mepc_out
);
  logic              mst_mie, mst_mpie;
  logic [31:0]       mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic [CNT_W-1:0]  mcycle_q, minstret_q, cy_nxt, ir_nxt;
  logic [31:0]       mstatus, old_val, wval, wval_m;
  logic              w_ill, wr_en, evt_blk, cy_inh, ir_inh;

`ifdef CSR_MCOUNTINHIBIT_EN
  logic [31:0] mcinh_q;
  assign cy_inh = mcinh_q[0];
  assign ir_inh = mcinh_q[2];
`else
  assign cy_inh = 1'b0;
  assign ir_inh = 1'b0;
`endif

  // MPP is hardwired to machine mode
  assign mstatus = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};

  function automatic logic impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14: return 1'b1;
`ifdef CSR_MCOUNTINHIBIT_EN
      12'h320: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] csr_read(input logic [11:0] a);
    case (a)
      12'h300:          return mstatus;
      12'h301:          return misa;
      12'h304:          return mie_q;
      12'h305:          return mtvec_q;
      12'h340:          return mscratch_q;
      12'h341:          return mepc_q;
      12'h342:          return mcause_q;
      12'h343:          return mtval_q;
      12'h344:          return mip_q;
      12'hB00, 12'hC00: return mcycle_q[31:0];
      12'hB02, 12'hC02: return minstret_q[31:0];
      12'hB80, 12'hC80: return 32'(mcycle_q >> 32);
      12'hB82, 12'hC82: return 32'(minstret_q >> 32);
      12'hF14:          return cpu_id;
`ifdef CSR_MCOUNTINHIBIT_EN
      12'h320:          return mcinh_q;
`endif
      default:          return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] wmask(input logic [11:0] a);
    case (a)
      12'h300:                            return 32'h0000_0088;
      12'h304:                            return 32'h0000_0888;
      12'h305:                            return 32'hFFFF_FFFD;
      12'h341:                            return 32'hFFFF_FFFC;
      12'h340, 12'h342, 12'h343,
      12'hB00, 12'hB02, 12'hB80, 12'hB82: return 32'hFFFF_FFFF;
`ifdef CSR_MCOUNTINHIBIT_EN
      12'h320:                            return 32'h0000_0005;
`endif
      default:                            return 32'h0;
    endcase
  endfunction

  assign csr.csr_rdata   = csr_read(csr.csr_raddr);
  assign w_ill           = !impl(csr.csr_waddr) || (csr.csr_waddr[11:10] == 2'b11);
  assign csr.illegal_csr = !impl(csr.csr_raddr) || ((csr.csr_op != 2'b00) && w_ill);

  // A trap or mret owns the registers it updates; a colliding CSR write loses
  assign evt_blk = (trap_valid && (csr.csr_waddr inside {12'h300, 12'h341, 12'h342, 12'h343}))
                || (mret_valid && (csr.csr_waddr == 12'h300));

  always_comb begin
    old_val = csr_read(csr.csr_waddr);
    case (csr.csr_op)
      2'b01:   wval = csr.csr_wdata;
      2'b10:   wval = old_val | csr.csr_wdata;
      2'b11:   wval = old_val & ~csr.csr_wdata;
      default: wval = old_val;
    endcase
    wval_m = wval & wmask(csr.csr_waddr);
    wr_en  = (csr.csr_op != 2'b00) && !w_ill && !evt_blk;
  end

  // Written half replaces the incremented value; the other half keeps it
  always_comb begin
    cy_nxt = mcycle_q + (cy_inh ? CNT_W'(0) : CNT_W'(1));
    ir_nxt = minstret_q + (ir_inh ? CNT_W'(0) : CNT_W'(retire_cnt));
    if (wr_en) begin
      case (csr.csr_waddr)
        12'hB00: cy_nxt[31:0]       = wval_m;
        12'hB80: cy_nxt[CNT_W-1:32] = wval_m[CNT_W-33:0];
        12'hB02: ir_nxt[31:0]       = wval_m;
        12'hB82: ir_nxt[CNT_W-1:32] = wval_m[CNT_W-33:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
`ifdef CSR_MCOUNTINHIBIT_EN
      mcinh_q    <= '0;
`endif
    end else begin
      mip_q      <= {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
      mcycle_q   <= cy_nxt;
      minstret_q <= ir_nxt;
      if (wr_en) begin
        case (csr.csr_waddr)
          12'h300: begin
            mst_mie  <= wval_m[3];
            mst_mpie <= wval_m[7];
          end
          12'h304: mie_q      <= wval_m;
          12'h305: mtvec_q    <= wval_m;
          12'h340: mscratch_q <= wval_m;
          12'h341: mepc_q     <= wval_m;
          12'h342: mcause_q   <= wval_m;
          12'h343: mtval_q    <= wval_m;
`ifdef CSR_MCOUNTINHIBIT_EN
          12'h320: mcinh_q    <= wval_m;
`endif
          default: ;
        endcase
      end
      if (trap_valid) begin
        mepc_q   <= trap_pc & ~32'h3;
        mcause_q <= trap_cause;
        mtval_q  <= trap_tval;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (mret_valid) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end
    end
  end

  assign irq_pending = mst_mie && |(mip_q & mie_q);
  assign trap_vector = (mtvec_q[0] && trap_cause[31])
                     ? {mtvec_q[31:2], 2'b00} + {25'b0, trap_cause[4:0], 2'b00}
                     : {mtvec_q[31:2], 2'b00};
  assign mepc_out    = mepc_q;
endmodule

// File: tb/tb_riscv_csr_trap_unit.sv
// Directed + randomized bench for riscv_csr_trap_unit against a behavioural CSR model.
module tb_riscv_csr_trap_unit;
  logic        clk = 1'b0;
  logic        srst;
  logic [31:0] cpu_id = 32'h0000_0005;
  logic [31:0] misa   = 32'h4000_1100;
  logic [1:0]  retire_cnt;
  logic        trap_valid, mret_valid, irq_ext, irq_timer, irq_sw;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        irq_pending;
  logic [31:0] trap_vector, mepc_out;
  logic        chk_en = 1'b0;
  int          n_cmp = 0, n_fail = 0;

  riscv_csr_trap_unit_if bus ();

  riscv_csr_trap_unit #(.CNT_W(64), .NUM_RETIRE(2)) dut (
    .clk(clk), .srst(srst), .cpu_id(cpu_id), .misa(misa), .csr(bus),
    .retire_cnt(retire_cnt), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .irq_pending(irq_pending), .trap_vector(trap_vector), .mepc_out(mepc_out)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: architectural CSR words, counters as 64-bit integers
  bit [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip, m_inh;
  bit [63:0] m_cyc, m_ins;

  function automatic bit m_impl(bit [11:0] a);
    bit r = a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                      12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80,
                      12'hC82, 12'hF14};
`ifdef CSR_MCOUNTINHIBIT_EN
    r = r || (a == 12'h320);
`endif
    return r;
  endfunction

  function automatic bit [31:0] m_rd(bit [11:0] a);
    if (!m_impl(a)) return 32'h0;
    case (a)
      12'h300: return m_mstatus | 32'h1800;
      12'h301: return misa;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'h320: return m_inh;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'hF14: return cpu_id;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit [31:0] m_wmask(bit [11:0] a);
    case (a)
      12'h300: return 32'h88;
      12'h304: return 32'h888;
      12'h305: return 32'hFFFF_FFFD;
      12'h341: return 32'hFFFF_FFFC;
      12'h320: return 32'h5;
      12'h340, 12'h342, 12'h343, 12'hB00, 12'hB02, 12'hB80, 12'hB82: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model_step
    bit [31:0] old, v;
    bit [63:0] cy, ins;
    bit        legal;
    if (srst) begin
      {m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip, m_inh} = '0;
      m_cyc = 0;
      m_ins = 0;
    end else begin
      cy  = m_cyc + (m_inh[0] ? 64'd0 : 64'd1);
      ins = m_ins + (m_inh[2] ? 64'd0 : 64'(retire_cnt));
      legal = bus.csr_op != 0 && m_impl(bus.csr_waddr) && bus.csr_waddr[11:10] != 2'b11
           && !(trap_valid && bus.csr_waddr inside {12'h300, 12'h341, 12'h342, 12'h343})
           && !(mret_valid && bus.csr_waddr == 12'h300);
      if (legal) begin
        old = m_rd(bus.csr_waddr);
        v = (bus.csr_op == 2'b01) ? bus.csr_wdata :
            (bus.csr_op == 2'b10) ? (old | bus.csr_wdata) : (old & ~bus.csr_wdata);
        v &= m_wmask(bus.csr_waddr);
        case (bus.csr_waddr)
          12'h300: m_mstatus  = v;
          12'h304: m_mie      = v;
          12'h305: m_mtvec    = v;
          12'h340: m_mscratch = v;
          12'h341: m_mepc     = v;
          12'h342: m_mcause   = v;
          12'h343: m_mtval    = v;
          12'h320: m_inh      = v;
          12'hB00: cy[31:0]   = v;
          12'hB80: cy[63:32]  = v;
          12'hB02: ins[31:0]  = v;
          12'hB82: ins[63:32] = v;
          default: ;
        endcase
      end
      if (trap_valid) begin
        m_mepc    = trap_pc & ~32'h3;
        m_mcause  = trap_cause;
        m_mtval   = trap_tval;
        m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      end else if (mret_valid) begin
        m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end
      m_mip = (irq_ext ? 32'h800 : 0) | (irq_timer ? 32'h80 : 0) | (irq_sw ? 32'h8 : 0);
      m_cyc = cy;
      m_ins = ins;
    end
  end

  // Compare process: every cycle, mid low phase
  always @(negedge clk) begin
    if (chk_en) begin : cmp
      bit [31:0] base, tv;
      bit        ill;
      #2;
      base = m_mtvec & ~32'h3;
      tv   = (m_mtvec[0] && trap_cause[31]) ? base + {25'b0, trap_cause[4:0], 2'b00} : base;
      ill  = !m_impl(bus.csr_raddr) || (bus.csr_op != 0 &&
             (!m_impl(bus.csr_waddr) || bus.csr_waddr[11:10] == 2'b11));
      chk("m_rdata", bus.csr_rdata, m_rd(bus.csr_raddr));
      chk("m_illegal", 32'(bus.illegal_csr), 32'(ill));
      chk("m_irq_pending", 32'(irq_pending), 32'(m_mstatus[3] && |(m_mip & m_mie)));
      chk("m_trap_vector", trap_vector, tv);
      chk("m_mepc_out", mepc_out, m_mepc);
    end
  end

  task automatic nxt();
    @(negedge clk);
    bus.csr_op = 2'b00;
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    retire_cnt = 2'd0;
  endtask

  task automatic wr(bit [1:0] op, bit [11:0] a, bit [31:0] d);
    bus.csr_op = op;
    bus.csr_waddr = a;
    bus.csr_wdata = d;
  endtask

  function automatic bit [11:0] pick();
    bit [11:0] tbl [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                             12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
                             12'hC02, 12'hC80, 12'hC82, 12'hF14, 12'h320, 12'h7C0};
    int k = $urandom_range(0, 20);
    return (k == 20) ? 12'($urandom) : tbl[k];
  endfunction

  initial begin
    srst = 1'b1;
    {retire_cnt, trap_valid, mret_valid, irq_ext, irq_timer, irq_sw} = '0;
    {trap_cause, trap_pc, trap_tval} = '0;
    bus.csr_raddr = 12'h0; bus.csr_waddr = 12'h0; bus.csr_wdata = 32'h0; bus.csr_op = 2'b00;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    chk_en = 1'b1;
    bus.csr_raddr = 12'h300;
    #3 chk("reset_mstatus", bus.csr_rdata, 32'h0000_1800);
    chk("reset_illegal", 32'(bus.illegal_csr), 32'h0);
    chk("reset_irq", 32'(irq_pending), 32'h0);
    chk("reset_tvec", trap_vector, 32'h0);
    chk("reset_mepc", mepc_out, 32'h0);
    nxt();
    nxt(); bus.csr_raddr = 12'hB00;
    #3 chk("mcycle_after_reset", bus.csr_rdata, 32'd2);

    // vectored mtvec
    nxt(); wr(2'b01, 12'h305, 32'h8000_0101); trap_cause = 32'h8000_0007;
    nxt(); bus.csr_raddr = 12'h305;
    #3 chk("mtvec_rd", bus.csr_rdata, 32'h8000_0101);
    chk("tvec_vectored", trap_vector, 32'h8000_011C);
    trap_cause = 32'h0000_0002;
    #1 chk("tvec_exception", trap_vector, 32'h8000_0100);

    // interrupt pending, trap entry, mret
    nxt(); wr(2'b01, 12'h300, 32'h8);
    nxt(); wr(2'b01, 12'h304, 32'h80);
    nxt(); irq_timer = 1'b1;
    #3 chk("irq_latency0", 32'(irq_pending), 32'h0);
    nxt();
    #3 chk("irq_latency1", 32'(irq_pending), 32'h1);
    trap_valid = 1'b1; trap_pc = 32'h1002; trap_cause = 32'h8000_0007; trap_tval = 32'hABCD;
    nxt(); bus.csr_raddr = 12'h341;
    #3 chk("trap_mepc", bus.csr_rdata, 32'h1000);
    chk("trap_mepc_out", mepc_out, 32'h1000);
    chk("trap_irq_off", 32'(irq_pending), 32'h0);
    bus.csr_raddr = 12'h300;
    #1 chk("trap_mstatus", bus.csr_rdata, 32'h1880);
    mret_valid = 1'b1;
    nxt(); bus.csr_raddr = 12'h300;
    #3 chk("mret_mstatus", bus.csr_rdata, 32'h1888);
    irq_timer = 1'b0;

    // set/clear and trap-vs-write priority
    nxt(); wr(2'b10, 12'h340, 32'h0F);
    nxt(); wr(2'b11, 12'h340, 32'h03); bus.csr_raddr = 12'h340;
    #3 chk("rs_mscratch", bus.csr_rdata, 32'h0F);
    nxt();
    #3 chk("rc_mscratch", bus.csr_rdata, 32'h0C);
    trap_valid = 1'b1; trap_pc = 32'h3007; wr(2'b01, 12'h341, 32'h2000);
    nxt(); bus.csr_raddr = 12'h341;
    #3 chk("trap_beats_write", bus.csr_rdata, 32'h3004);

    // counter halves and carry
    nxt(); wr(2'b01, 12'hB80, 32'h0);
    nxt(); wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    nxt(); bus.csr_raddr = 12'hB00;
    #3 chk("mcycle_lo_written", bus.csr_rdata, 32'hFFFF_FFFF);
    nxt(); bus.csr_raddr = 12'hB80;
    #3 chk("mcycle_carry", bus.csr_rdata, 32'h1);
    repeat (5) begin nxt(); retire_cnt = 2'd2; end
    nxt(); bus.csr_raddr = 12'hB02;
    #3 chk("minstret_multi", bus.csr_rdata, 32'd10);

    // illegal write to read-only alias
    nxt(); wr(2'b01, 12'hB00, 32'h100);
    nxt(); wr(2'b01, 12'hC00, 32'h0); bus.csr_raddr = 12'hB00;
    #3 chk("ro_alias_illegal", 32'(bus.illegal_csr), 32'h1);
    chk("mcycle_pre", bus.csr_rdata, 32'h100);
    nxt();
    #3 chk("mcycle_untouched", bus.csr_rdata, 32'h101);
`ifdef CSR_MCOUNTINHIBIT_EN
    nxt(); wr(2'b01, 12'hB00, 32'h200);
    nxt(); wr(2'b01, 12'h320, 32'h1);
    repeat (10) nxt();
    bus.csr_raddr = 12'hB00;
    #3 chk("mcycle_inhibited", bus.csr_rdata, 32'h201);
    nxt(); wr(2'b01, 12'h320, 32'h0);
`else
    nxt(); bus.csr_raddr = 12'h320;
    #3 chk("mcinh_absent_ill", 32'(bus.illegal_csr), 32'h1);
    chk("mcinh_absent_rd", bus.csr_rdata, 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      nxt();
      srst = ($urandom_range(0, 499) == 0);
      bus.csr_raddr = pick();
      wr(2'($urandom), pick(), $urandom);
      trap_valid = ($urandom_range(0, 9) == 0);
      mret_valid = ($urandom_range(0, 9) == 0);
      trap_cause = $urandom;
      trap_pc    = $urandom;
      trap_tval  = $urandom;
      retire_cnt = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) {irq_ext, irq_timer, irq_sw} = 3'($urandom);
    end
    nxt();
    srst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
